tri_raster_scan: RTL and testbench
==================================

Name: tri_raster_scan

Overview:
- Triangle rasterizer front end. Accepts one screen-space triangle, scans its clamped bounding box, and emits a stream of covered pixel coordinates.
- Coverage uses incremental edge functions in the same form as the point-in-triangle test in the triangles package, so the two agree exactly.
- Sits between the vertex projection stage and the pixel shading/framebuffer writer.

Parameters:
- COORD_W, 12: signed vertex coordinate width (two's complement).
- SCREEN_W, 320: screen width in pixels; x range is 0..SCREEN_W-1.
- SCREEN_H, 240: screen height in pixels; y range is 0..SCREEN_H-1.
- CNT_W, 17: width of the per-triangle pixel counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  triangle present
- in_ready  out  1  block can accept a triangle; high only in IDLE
- in_v0x, in_v0y, in_v1x, in_v1y, in_v2x, in_v2y  in  COORD_W each  signed vertices
- out_valid  out  1  pixel valid
- out_ready  in  1  downstream accepts pixel
- out_x  out  $clog2(SCREEN_W)  pixel x
- out_y  out  $clog2(SCREEN_H)  pixel y
- tri_done  out  1  one-cycle pulse marking the end of the triangle
- tri_pixels  out  CNT_W  pixels emitted for the triangle; valid while tri_done is high

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - out_valid=0, out_x=0, out_y=0, tri_done=0, tri_pixels=0.
  - in_ready=1, because in_ready is decoded from state==IDLE.
- States are IDLE, SETUP, SCAN, DONE.
- IDLE: when in_valid && in_ready, latch the vertices and go to SETUP.
- SETUP (exactly 1 cycle):
  - Compute area = det2d(v0,v1,v2) = v0x*(v1y-v2y) + v1x*(v2y-v0y) + v2x*(v0y-v1y).
  - Compute the bbox from vertex min/max, clamped to the screen.
  - Compute start edge values at (bx_min, by_min):
    - E0 = sign(p,v0,v1)
    - E1 = sign(p,v1,v2)
    - E2 = sign(p,v2,v0)
    - where sign(p,a,b) = (px-bx)*(ay-by) - (ax-bx)*(py-by).
  - Compute per-edge steps: dx = (ay-by) and dy = -(ax-bx).
  - Go to DONE instead of SCAN if area==0 (degenerate), or if the clamped bbox is empty (max<0, min>screen-1, or min>max).
- Edge arithmetic:
  - All edge arithmetic is signed, EDGE_W = 2*COORD_W+3 bits, with no saturation.
  - X stepping adds dx. Row wrap reloads the saved row-start value plus dy.
- SCAN:
  - Evaluates one bbox position per cycle, row-major: x increments first; at bx_max x wraps to bx_min and y increments.
  - A position is covered if NOT(any Ei<0 AND any Ei>0). Edges are inclusive and both windings are accepted.
  - A covered position loads the output register: out_valid=1, out_x/out_y = position, and the counter increments.
  - While out_valid && !out_ready, the scan stalls. Edge values, position and the output register all hold.
  - out_valid drops the cycle after acceptance unless the next position is covered.
  - After position (bx_max, by_max) is evaluated and no output is pending, go to DONE.
- DONE (1 cycle):
  - tri_done=1 and tri_pixels = count.
  - Then go to IDLE; the counter clears on the next accept.
- Latency:
  - Accept to first evaluation is 2 cycles.
  - Throughput is 1 pixel/cycle with out_ready held high.
- Reset asserted mid-operation aborts the triangle immediately and produces no tri_done.

Optional Feature:
- Macro: TRI_RASTER_BACKFACE_CULL_EN.
- Defined:
  - A triangle with area<=0 goes straight to DONE with tri_pixels=0.
  - Coverage requires all Ei>=0.
- Undefined:
  - Both windings are rasterized per the inclusive rule above.
  - Only area==0 is culled.

Decomposition:
- Shared package raster_pkg holds:
  - COORD_W and EDGE_W constants.
  - typedef coord_t (signed COORD_W).
  - typedef edge_t (signed EDGE_W).
  - struct tri_t (three x/y vertex pairs).
  - enum raster_state_t.
  - An integer edge_setup function returning the value, dx and dy.
- One sub-module is natural: tri_edge_stepper, instantiated ×3. It holds the current and row-start values, with load, step_x, step_row and hold controls.

Test Plan:
- (0,0),(4,0),(0,4), out_ready=1 -> 15 pixels with x+y<=4 in row-major order; first (0,0), last (0,4); tri_pixels=15; tri_done once.
- (0,0),(0,4),(4,0) -> same 15 pixels and order when the macro is undefined; with TRI_RASTER_BACKFACE_CULL_EN defined -> 0 pixels, tri_done with tri_pixels=0.
- Collinear (0,0),(2,2),(4,4) -> no out_valid; tri_done 2 cycles after accept; tri_pixels=0.
- SCREEN 8x8, vertices (-4,-4),(20,-4),(-4,20) -> all 64 pixels (0,0)..(7,7); triangle (-10,-10),(-5,-10),(-10,-5) -> bbox empty, tri_pixels=0.
- Case 1 with out_ready random 30% high -> identical pixel sequence and count; out_x/out_y stable while stalled; no drops or duplicates.
- rst_n low during SCAN after 5 pixels -> out_valid=0 asynchronously, no tri_done; a following triangle is processed normally from IDLE.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types and helpers for the triangle rasterizer front end.
// Optional feature macro used by the top: TRI_RASTER_BACKFACE_CULL_EN.
package raster_pkg;

    localparam int COORD_W = 12;
    localparam int EDGE_W  = 2 * COORD_W + 3;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [EDGE_W-1:0]  edge_t;

    typedef struct packed {
        coord_t v0x;
        coord_t v0y;
        coord_t v1x;
        coord_t v1y;
        coord_t v2x;
        coord_t v2y;
    } tri_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } raster_state_t;

    // Start value of one edge function plus its x and row increments.
    typedef struct packed {
        edge_t value;
        edge_t dx;
        edge_t dy;
    } edge_init_t;

    // sign(p,a,b) = (px-bx)*(ay-by) - (ax-bx)*(py-by); stepping x adds
    // (ay-by), stepping y adds -(ax-bx).
    function automatic edge_init_t edge_setup(input coord_t px, input coord_t py,
                                              input coord_t ax, input coord_t ay,
                                              input coord_t bx, input coord_t by);
        edge_init_t r;
        edge_t      pxe, pye, axe, aye, bxe, bye;
        pxe = edge_t'(px);
        pye = edge_t'(py);
        axe = edge_t'(ax);
        aye = edge_t'(ay);
        bxe = edge_t'(bx);
        bye = edge_t'(by);
        r.value = (pxe - bxe) * (aye - bye) - (axe - bxe) * (pye - bye);
        r.dx    = aye - bye;
        r.dy    = bxe - axe;
        return r;
    endfunction

    // Twice the signed triangle area; zero for degenerate triangles.
    function automatic edge_t det2d(input tri_t t);
        edge_t x0, y0, x1, y1, x2, y2;
        x0 = edge_t'(t.v0x);
        y0 = edge_t'(t.v0y);
        x1 = edge_t'(t.v1x);
        y1 = edge_t'(t.v1y);
        x2 = edge_t'(t.v2x);
        y2 = edge_t'(t.v2y);
        return x0 * (y1 - y2) + x1 * (y2 - y0) + x2 * (y0 - y1);
    endfunction

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Clamp into 0..lim.
    function automatic coord_t clamp(input coord_t v, input coord_t lim);
        if (v < 0) begin
            return '0;
        end
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/tri_edge_stepper.sv
// Incremental evaluator for one edge function. Keeps the current value and
// the value at the start of the current row so a row wrap is one add.
module tri_edge_stepper
    import raster_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       hold_i,
    input  logic       step_x_i,
    input  logic       step_row_i,
    input  edge_init_t init_i,
    output edge_t      e_o
);

    edge_t cur_q, cur_d;
    edge_t row_q, row_d;
    edge_t dx_q, dx_d;
    edge_t dy_q, dy_d;

    // Next value: load wins, then hold, then row wrap, then x step.
    always_comb begin
        cur_d = cur_q;
        row_d = row_q;
        dx_d  = dx_q;
        dy_d  = dy_q;
        if (load_i) begin
            cur_d = init_i.value;
            row_d = init_i.value;
            dx_d  = init_i.dx;
            dy_d  = init_i.dy;
        end else if (!hold_i) begin
            if (step_row_i) begin
                cur_d = row_q + dy_q;
                row_d = row_q + dy_q;
            end else if (step_x_i) begin
                cur_d = cur_q + dx_q;
            end
        end
    end

    // Edge state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q <= '0;
            row_q <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
        end else begin
            cur_q <= cur_d;
            row_q <= row_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
        end
    end

    assign e_o = cur_q;

endmodule

// File: rtl/tri_raster_scan.sv
// Triangle rasterizer front end: latches one triangle, scans its clamped
// bounding box row-major at one position per cycle and streams covered
// pixels. Handshake: a transfer happens on a rising edge where valid and
// ready are both high; out_valid, once high, holds with out_x/out_y stable
// until out_ready is seen.
// Optional: define TRI_RASTER_BACKFACE_CULL_EN to drop triangles with
// area<=0 and require all edge values >= 0.
module tri_raster_scan #(
    parameter int COORD_W  = 12,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int CNT_W    = 17
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [COORD_W-1:0]   in_v0x,
    input  logic signed [COORD_W-1:0]   in_v0y,
    input  logic signed [COORD_W-1:0]   in_v1x,
    input  logic signed [COORD_W-1:0]   in_v1y,
    input  logic signed [COORD_W-1:0]   in_v2x,
    input  logic signed [COORD_W-1:0]   in_v2y,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(SCREEN_W)-1:0] out_x,
    output logic [$clog2(SCREEN_H)-1:0] out_y,
    output logic                        tri_done,
    output logic [CNT_W-1:0]            tri_pixels
);
    import raster_pkg::*;

    localparam int     XW    = $clog2(SCREEN_W);
    localparam int     YW    = $clog2(SCREEN_H);
    localparam coord_t X_LIM = coord_t'(SCREEN_W - 1);
    localparam coord_t Y_LIM = coord_t'(SCREEN_H - 1);

    raster_state_t state_q, state_d;
    tri_t          tri_q, tri_d;
    logic [XW-1:0] bx_min_q, bx_min_d;
    logic [XW-1:0] bx_max_q, bx_max_d;
    logic [YW-1:0] by_max_q, by_max_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          end_q, end_d;
    logic          out_valid_q, out_valid_d;
    logic [XW-1:0] out_x_q, out_x_d;
    logic [YW-1:0] out_y_q, out_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    tri_t       tri_in;
    coord_t     minx, maxx, miny, maxy;
    coord_t     bx_min_c, bx_max_c, by_min_c, by_max_c;
    logic       bbox_empty;
    edge_t      area;
    logic       cull;
    edge_init_t init0, init1, init2;
    edge_t      e0, e1, e2;
    logic       covered;
    logic       stall;
    logic       st_load, st_hold, st_x, st_row;

    assign tri_in.v0x = in_v0x;
    assign tri_in.v0y = in_v0y;
    assign tri_in.v1x = in_v1x;
    assign tri_in.v1y = in_v1y;
    assign tri_in.v2x = in_v2x;
    assign tri_in.v2y = in_v2y;

    // Setup math on the latched triangle; only consumed in SETUP.
    assign minx     = min3(tri_q.v0x, tri_q.v1x, tri_q.v2x);
    assign maxx     = max3(tri_q.v0x, tri_q.v1x, tri_q.v2x);
    assign miny     = min3(tri_q.v0y, tri_q.v1y, tri_q.v2y);
    assign maxy     = max3(tri_q.v0y, tri_q.v1y, tri_q.v2y);
    assign bx_min_c = clamp(minx, X_LIM);
    assign bx_max_c = clamp(maxx, X_LIM);
    assign by_min_c = clamp(miny, Y_LIM);
    assign by_max_c = clamp(maxy, Y_LIM);

    assign bbox_empty = (maxx < 0) || (maxy < 0) ||
                        (minx > X_LIM) || (miny > Y_LIM) ||
                        (bx_min_c > bx_max_c) || (by_min_c > by_max_c);

    assign area  = det2d(tri_q);
    assign init0 = edge_setup(bx_min_c, by_min_c, tri_q.v0x, tri_q.v0y, tri_q.v1x, tri_q.v1y);
    assign init1 = edge_setup(bx_min_c, by_min_c, tri_q.v1x, tri_q.v1y, tri_q.v2x, tri_q.v2y);
    assign init2 = edge_setup(bx_min_c, by_min_c, tri_q.v2x, tri_q.v2y, tri_q.v0x, tri_q.v0y);

`ifdef TRI_RASTER_BACKFACE_CULL_EN
    // Only front-facing (positive area) triangles survive; inside is all >= 0.
    assign cull    = (area <= 0);
    assign covered = !e0[EDGE_W-1] && !e1[EDGE_W-1] && !e2[EDGE_W-1];
`else
    logic any_neg, any_pos;
    // Either winding is inside when no two edges disagree in strict sign.
    assign cull    = (area == '0);
    assign any_neg = e0[EDGE_W-1] || e1[EDGE_W-1] || e2[EDGE_W-1];
    assign any_pos = (!e0[EDGE_W-1] && (e0 != '0)) ||
                     (!e1[EDGE_W-1] && (e1 != '0)) ||
                     (!e2[EDGE_W-1] && (e2 != '0));
    assign covered = !(any_neg && any_pos);
`endif

    assign stall = out_valid_q && !out_ready;

    tri_edge_stepper u_edge0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (st_load),
        .hold_i     (st_hold),
        .step_x_i   (st_x),
        .step_row_i (st_row),
        .init_i     (init0),
        .e_o        (e0)
    );

    tri_edge_stepper u_edge1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (st_load),
        .hold_i     (st_hold),
        .step_x_i   (st_x),
        .step_row_i (st_row),
        .init_i     (init1),
        .e_o        (e1)
    );

    tri_edge_stepper u_edge2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (st_load),
        .hold_i     (st_hold),
        .step_x_i   (st_x),
        .step_row_i (st_row),
        .init_i     (init2),
        .e_o        (e2)
    );

    // Next-state, scan position, output register and stepper controls.
    always_comb begin
        state_d     = state_q;
        tri_d       = tri_q;
        bx_min_d    = bx_min_q;
        bx_max_d    = bx_max_q;
        by_max_d    = by_max_q;
        x_d         = x_q;
        y_d         = y_q;
        end_d       = end_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        cnt_d       = cnt_q;
        st_load     = 1'b0;
        st_hold     = 1'b1;
        st_x        = 1'b0;
        st_row      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    tri_d   = tri_in;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                bx_min_d = bx_min_c[XW-1:0];
                bx_max_d = bx_max_c[XW-1:0];
                by_max_d = by_max_c[YW-1:0];
                x_d      = bx_min_c[XW-1:0];
                y_d      = by_min_c[YW-1:0];
                end_d    = 1'b0;
                if (cull || bbox_empty) begin
                    state_d = ST_DONE;
                end else begin
                    st_load = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (end_q) begin
                    // Every position evaluated; drain the last pixel.
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_DONE;
                    end
                end else if (!stall) begin
                    st_hold     = 1'b0;
                    out_valid_d = covered;
                    if (covered) begin
                        out_x_d = x_q;
                        out_y_d = y_q;
                        cnt_d   = cnt_q + 1'b1;
                    end
                    if (x_q == bx_max_q) begin
                        if (y_q == by_max_q) begin
                            if (covered) begin
                                end_d = 1'b1;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            st_row = 1'b1;
                            x_d    = bx_min_q;
                            y_d    = y_q + 1'b1;
                        end
                    end else begin
                        st_x = 1'b1;
                        x_d  = x_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tri_q       <= '0;
            bx_min_q    <= '0;
            bx_max_q    <= '0;
            by_max_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            end_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            tri_q       <= tri_d;
            bx_min_q    <= bx_min_d;
            bx_max_q    <= bx_max_d;
            by_max_q    <= by_max_d;
            x_q         <= x_d;
            y_q         <= y_d;
            end_q       <= end_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign tri_done   = (state_q == ST_DONE);
    assign tri_pixels = cnt_q;
    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;

endmodule

// File: tb/tb_tri_raster_scan.sv
// Directed bench for tri_raster_scan: a 320x240 instance and an 8x8 instance
// share clock, reset, vertices and out_ready; sel picks which one is driven
// and observed.
module tb_tri_raster_scan;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic sel;
    logic out_ready;
    logic signed [11:0] v0x, v0y, v1x, v1y, v2x, v2y;

    logic        rdy_a, ov_a, done_a;
    logic [8:0]  x_a;
    logic [7:0]  y_a;
    logic [16:0] pix_a;
    logic        rdy_b, ov_b, done_b;
    logic [2:0]  x_b;
    logic [2:0]  y_b;
    logic [16:0] pix_b;

    logic        in_valid_a, in_valid_b;
    logic        rdy_m, ov_m, done_m;
    logic [31:0] xy_m, pix_m;

    logic [31:0] exp_q[$];
    int          n_cmp;
    int          n_err;

    assign in_valid_a = in_valid && !sel;
    assign in_valid_b = in_valid && sel;
    assign rdy_m  = sel ? rdy_b  : rdy_a;
    assign ov_m   = sel ? ov_b   : ov_a;
    assign done_m = sel ? done_b : done_a;
    assign xy_m   = sel ? {13'd0, x_b, 13'd0, y_b} : {7'd0, x_a, 8'd0, y_a};
    assign pix_m  = sel ? {15'd0, pix_b} : {15'd0, pix_a};

    tri_raster_scan #(.COORD_W(12), .SCREEN_W(320), .SCREEN_H(240), .CNT_W(17)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_a),
        .in_ready   (rdy_a),
        .in_v0x     (v0x),
        .in_v0y     (v0y),
        .in_v1x     (v1x),
        .in_v1y     (v1y),
        .in_v2x     (v2x),
        .in_v2y     (v2y),
        .out_valid  (ov_a),
        .out_ready  (out_ready),
        .out_x      (x_a),
        .out_y      (y_a),
        .tri_done   (done_a),
        .tri_pixels (pix_a)
    );

    tri_raster_scan #(.COORD_W(12), .SCREEN_W(8), .SCREEN_H(8), .CNT_W(17)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_b),
        .in_ready   (rdy_b),
        .in_v0x     (v0x),
        .in_v0y     (v0y),
        .in_v1x     (v1x),
        .in_v1y     (v1y),
        .in_v2x     (v2x),
        .in_v2y     (v2y),
        .out_valid  (ov_b),
        .out_ready  (out_ready),
        .out_x      (x_b),
        .out_y      (y_b),
        .tri_done   (done_b),
        .tri_pixels (pix_b)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int x, input int y);
        logic [31:0] r;
        r = {x[15:0], y[15:0]};
        return r;
    endfunction

    // Expected stream for the right triangle (0,0),(4,0),(0,4): x+y<=4.
    task automatic load_exp_tri4();
        exp_q.delete();
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4; x++)
                if (x + y <= 4) exp_q.push_back(pk(x, y));
    endtask

    task automatic load_exp_full8();
        exp_q.delete();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                exp_q.push_back(pk(x, y));
    endtask

    // Drive one triangle and scoreboard its pixel stream.
    // done_cyc/first_cyc < 0 skip the timing check; abort_after > 0 resets
    // the DUTs after that many accepted pixels.
    task automatic run_tri(input logic s, input int ax, input int ay, input int bx,
                           input int by, input int cx, input int cy, input int pct,
                           input int exp_cnt, input int done_cyc, input int first_cyc,
                           input int abort_after);
        int          cyc;
        int          seen;
        bit          done_seen;
        bit          aborted;
        bit          stalled;
        bit          first_seen;
        logic [31:0] prev_xy;
        @(negedge clk);
        sel = s;
        v0x = 12'(ax); v0y = 12'(ay);
        v1x = 12'(bx); v1y = 12'(by);
        v2x = 12'(cx); v2y = 12'(cy);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check("in_ready_idle", {31'd0, rdy_m}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1; seen = 0; done_seen = 0; aborted = 0; stalled = 0; first_seen = 0;
        prev_xy = '0;
        while (cyc < 3000 && !done_seen && !aborted) begin
            if (cyc == 1) check("in_ready_busy", {31'd0, rdy_m}, 32'd0);
            if (stalled) begin
                check("stall_valid", {31'd0, ov_m}, 32'd1);
                check("stall_xy", xy_m, prev_xy);
            end
            if (ov_m && !first_seen) begin
                first_seen = 1;
                if (first_cyc >= 0) check("first_latency", cyc, first_cyc);
            end
            if (done_m) begin
                done_seen = 1;
                check("tri_pixels", pix_m, exp_cnt);
                check("pix_seen", seen, exp_cnt);
                if (done_cyc >= 0) check("done_latency", cyc, done_cyc);
            end else begin
                out_ready = ($urandom_range(0, 99) < pct);
                if (ov_m && out_ready) begin
                    seen++;
                    if (exp_q.size() > 0) check("pixel", xy_m, exp_q.pop_front());
                    else check("extra_pixel", xy_m, 32'hffff_ffff);
                end
                stalled = ov_m && !out_ready;
                prev_xy = xy_m;
                @(negedge clk);
                cyc++;
                if (abort_after > 0 && seen == abort_after) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check("abort_valid", {31'd0, ov_m}, 32'd0);
                    check("abort_ready", {31'd0, rdy_m}, 32'd1);
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        check("abort_no_done", {31'd0, done_m}, 32'd0);
                    end
                    rst_n = 1'b1;
                    exp_q.delete();
                    aborted = 1;
                end
            end
        end
        if (!aborted) begin
            if (!done_seen) check("timeout", 32'd0, 32'd1);
            @(negedge clk);
            check("done_once", {31'd0, done_m}, 32'd0);
            check("leftover", exp_q.size(), 0);
            exp_q.delete();
        end
        out_ready = 1'b1;
    endtask

    // Stimulus and report.
    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; out_ready = 1'b1;
        v0x = '0; v0y = '0; v1x = '0; v1y = '0; v2x = '0; v2y = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, ov_a}, 32'd0);
        check("rst_out_x", {23'd0, x_a}, 32'd0);
        check("rst_out_y", {24'd0, y_a}, 32'd0);
        check("rst_tri_done", {31'd0, done_a}, 32'd0);
        check("rst_tri_pixels", {15'd0, pix_a}, 32'd0);
        check("rst_in_ready", {31'd0, rdy_a}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Front-facing right triangle, full throughput.
        load_exp_tri4();
        run_tri(1'b0, 0, 0, 4, 0, 0, 4, 100, 15, -1, 3, 0);

        // Opposite winding.
`ifdef TRI_RASTER_BACKFACE_CULL_EN
        exp_q.delete();
        run_tri(1'b0, 0, 0, 0, 4, 4, 0, 100, 0, 2, -1, 0);
`else
        load_exp_tri4();
        run_tri(1'b0, 0, 0, 0, 4, 4, 0, 100, 15, -1, 3, 0);
`endif

        // Collinear: degenerate, straight to DONE.
        exp_q.delete();
        run_tri(1'b0, 0, 0, 2, 2, 4, 4, 100, 0, 2, -1, 0);

        // 8x8 screen: triangle covering every pixel after clamping.
        load_exp_full8();
        run_tri(1'b1, -4, -4, 20, -4, -4, 20, 100, 64, -1, 3, 0);

        // 8x8 screen: triangle fully off-screen.
        exp_q.delete();
        run_tri(1'b1, -10, -10, -5, -10, -10, -5, 100, 0, 2, -1, 0);

        // Back-pressure: ready high ~30% of the time.
        load_exp_tri4();
        run_tri(1'b0, 0, 0, 4, 0, 0, 4, 30, 15, -1, -1, 0);

        // Reset during scan after 5 pixels, then a clean triangle.
        load_exp_tri4();
        run_tri(1'b0, 0, 0, 4, 0, 0, 4, 100, 15, -1, -1, 5);
        @(negedge clk);
        load_exp_tri4();
        run_tri(1'b0, 0, 0, 4, 0, 0, 4, 100, 15, -1, 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
